// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback register file with bypassed read ports and busy-bit scoreboard
module wb_regfile #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_we,
  input  logic [ADDR_W-1:0]      wb_dest,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   rd_a_en,
  input  logic [ADDR_W-1:0]      rd_a_addr,
  input  logic                   rd_b_en,
  input  logic [ADDR_W-1:0]      rd_b_addr,
  output logic [DATA_W-1:0]      rd_a_data,
  output logic [DATA_W-1:0]      rd_b_data,
  input  logic                   issue_valid,
  input  logic                   issue_we,
  input  logic [ADDR_W-1:0]      issue_dest,
  output logic                   stall,
  output logic [(2**ADDR_W)-1:0] busy,
  output logic [7:0]             retire_count
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] val_a;
  logic [DATA_W-1:0] val_b;
  logic [NREGS-1:0]  busy_next;
  logic              wb_dest_zero;
  logic              issue_dest_zero;
  logic              commit;
  logic              hazard_a;
  logic              hazard_b;
  logic              issue_set;

  assign wb_dest_zero    = (ZERO_REG != 0) && (wb_dest == '0);
  assign issue_dest_zero = (ZERO_REG != 0) && (issue_dest == '0);
  assign commit          = wb_we && !wb_dest_zero;

  // A read that matches the in-flight writeback is satisfied by the bypass, so it is not a hazard.
  assign hazard_a  = rd_a_en && busy[rd_a_addr] && !(wb_we && (wb_dest == rd_a_addr));
  assign hazard_b  = rd_b_en && busy[rd_b_addr] && !(wb_we && (wb_dest == rd_b_addr));
  assign stall     = hazard_a || hazard_b;
  assign issue_set = issue_valid && !stall && issue_we && !issue_dest_zero;

  always_comb begin
    val_a = regs[rd_a_addr];
    if (wb_we && (wb_dest == rd_a_addr)) val_a = wb_data;
    if ((ZERO_REG != 0) && (rd_a_addr == '0)) val_a = '0;
  end

  always_comb begin
    val_b = regs[rd_b_addr];
    if (wb_we && (wb_dest == rd_b_addr)) val_b = wb_data;
    if ((ZERO_REG != 0) && (rd_b_addr == '0)) val_b = '0;
  end

  // Set after clear: a same-edge issue to the committing register is the newer outstanding write.
  always_comb begin
    busy_next = busy;
    if (commit)    busy_next[wb_dest]    = 1'b0;
    if (issue_set) busy_next[issue_dest] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      rd_a_data    <= '0;
      rd_b_data    <= '0;
      busy         <= '0;
      retire_count <= '0;
    end else begin
      if (commit) begin
        regs[wb_dest] <= wb_data;
        retire_count  <= retire_count + 8'd1;
      end
      if (rd_a_en) rd_a_data <= val_a;
      if (rd_b_en) rd_b_data <= val_b;
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed vector bench for wb_regfile
module tb_wb_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic       wb_we;
  logic [2:0] wb_dest;
  logic [7:0] wb_data;
  logic       rd_a_en;
  logic [2:0] rd_a_addr;
  logic       rd_b_en;
  logic [2:0] rd_b_addr;
  logic [7:0] rd_a_data;
  logic [7:0] rd_b_data;
  logic       issue_valid;
  logic       issue_we;
  logic [2:0] issue_dest;
  logic       stall;
  logic [7:0] busy;
  logic [7:0] retire_count;

  int compared = 0;
  int mismatched = 0;

  wb_regfile #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .rd_a_en(rd_a_en), .rd_a_addr(rd_a_addr),
    .rd_b_en(rd_b_en), .rd_b_addr(rd_b_addr),
    .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_dest(issue_dest),
    .stall(stall), .busy(busy), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [2:0] dest;
    logic [7:0] data;
    logic       ra_en;
    logic [2:0] ra;
    logic       rb_en;
    logic [2:0] rb;
    logic       iv;
    logic       iw;
    logic [2:0] id;
    logic       exp_stall;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [7:0] exp_busy;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_dest = 0; wb_data = 0;
    rd_a_en = 0; rd_a_addr = 0; rd_b_en = 0; rd_b_addr = 0;
    issue_valid = 0; issue_we = 0; issue_dest = 0;
  endtask

  initial begin
    //            we dest data  raen ra rben rb iv iw id  stall a      b      busy   cnt
    vecs[0]  = '{0, 0, 8'h00, 1, 3, 1, 5, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'd0};
    vecs[1]  = '{1, 2, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'd1};
    vecs[2]  = '{0, 0, 8'h00, 1, 2, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h00, 8'h00, 8'd1};
    vecs[3]  = '{0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 4, 0, 8'hA5, 8'h00, 8'h10, 8'd1};
    vecs[4]  = '{1, 4, 8'h3C, 0, 0, 1, 4, 0, 0, 0, 0, 8'hA5, 8'h3C, 8'h00, 8'd2};
    vecs[5]  = '{0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 6, 0, 8'hA5, 8'h3C, 8'h40, 8'd2};
    vecs[6]  = '{0, 0, 8'h00, 1, 6, 0, 0, 1, 1, 1, 1, 8'h00, 8'h3C, 8'h40, 8'd2};
    vecs[7]  = '{1, 6, 8'h77, 1, 6, 0, 0, 0, 0, 0, 0, 8'h77, 8'h3C, 8'h00, 8'd3};
    vecs[8]  = '{1, 0, 8'hFF, 1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h3C, 8'h00, 8'd3};
    vecs[9]  = '{1, 3, 8'h11, 0, 0, 1, 3, 1, 1, 3, 0, 8'h00, 8'h11, 8'h08, 8'd4};
    vecs[10] = '{0, 0, 8'h00, 1, 4, 1, 2, 0, 0, 0, 0, 8'h3C, 8'hA5, 8'h08, 8'd4};

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset_a", rd_a_data, 8'h00);
    chk("reset_b", rd_b_data, 8'h00);
    chk("reset_busy", busy, 8'h00);
    chk("reset_cnt", retire_count, 8'd0);
    chk("reset_stall", stall, 1'b0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      wb_we = vecs[i].we; wb_dest = vecs[i].dest; wb_data = vecs[i].data;
      rd_a_en = vecs[i].ra_en; rd_a_addr = vecs[i].ra;
      rd_b_en = vecs[i].rb_en; rd_b_addr = vecs[i].rb;
      issue_valid = vecs[i].iv; issue_we = vecs[i].iw; issue_dest = vecs[i].id;
      #1;
      chk($sformatf("v%0d_stall", i), stall, vecs[i].exp_stall);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_a", i), rd_a_data, vecs[i].exp_a);
      chk($sformatf("v%0d_b", i), rd_b_data, vecs[i].exp_b);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
      chk($sformatf("v%0d_cnt", i), retire_count, vecs[i].exp_cnt);
    end

    // 256 commits to r5 starting from count 4: one short of the full lap lands on 3.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      idle_inputs();
      wb_we = 1; wb_dest = 5; wb_data = i[7:0];
      @(posedge clk);
      #1;
      if (i == 254) chk("wrap_255", retire_count, 8'd3);
    end
    chk("wrap_256", retire_count, 8'd4);
    chk("wrap_busy", busy, 8'h08);
    @(negedge clk);
    idle_inputs();
    rd_a_en = 1; rd_a_addr = 5;
    @(posedge clk);
    #1;
    chk("wrap_last_data", rd_a_data, 8'hFF);

    // Reset mid-cycle with a pending hazard on r3 must clear everything at once.
    @(negedge clk);
    rd_b_en = 1; rd_b_addr = 3;
    #1;
    chk("pre_rst_stall", stall, 1'b1);
    rst = 1;
    #1;
    chk("rst_a", rd_a_data, 8'h00);
    chk("rst_b", rd_b_data, 8'h00);
    chk("rst_busy", busy, 8'h00);
    chk("rst_cnt", retire_count, 8'd0);
    chk("rst_stall", stall, 1'b0);
    @(negedge clk);
    rst = 0;
    idle_inputs();
    rd_a_en = 1; rd_a_addr = 2;
    @(posedge clk);
    #1;
    chk("post_rst_reg2", rd_a_data, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
